// File: rtl/voice_allocator.sv
// Polyphony scheduler: takes note start/stop commands and assigns them to the
// phase_bank voice pool by retrigger, free slot or oldest-voice steal.
module voice_allocator #(
    parameter int NUM_VOICES = 10,
    parameter int STAMP_W    = 8
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [15:0]             i_data,
    output logic                    o_ready,
    input  logic [NUM_VOICES-1:0]   i_state,
    output logic [NUM_VOICES-1:0]   o_cmd,
    output logic [7*NUM_VOICES-1:0] o_midi,
    output logic [8*NUM_VOICES-1:0] o_vel,
    output logic                    o_done,
    output logic                    o_drop,
    output logic                    o_steal,
    output logic [3:0]              o_active
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_APPLY,
        S_KILL,
        S_STOPALL,
        S_DROP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic               req_start;
    logic [6:0]         req_note;
    logic [7:0]         req_vel;

    logic [IDX_W-1:0]   k;
    logic               match_hit, free_hit;
    logic [IDX_W-1:0]   match_idx, free_idx, old_idx;
    logic [STAMP_W-1:0] old_age;
    logic               drop_flag, steal_flag;

    logic [6:0]         midi_r  [NUM_VOICES];
    logic [7:0]         vel_r   [NUM_VOICES];
    logic [STAMP_W-1:0] stamp_r [NUM_VOICES];
    logic [STAMP_W-1:0] stamp_now;

    logic               accept;
    logic               last_k;
    logic               scan_match, scan_free;
    logic [STAMP_W-1:0] age_k;
    logic [IDX_W-1:0]   target;
    logic               is_steal;
    logic [3:0]         active_cnt;

    assign o_ready    = (state == S_IDLE);
    assign accept     = i_valid && o_ready;
    assign last_k     = (k == IDX_W'(NUM_VOICES - 1));
    assign scan_match = o_cmd[k] && (midi_r[k] == req_note);
    assign scan_free  = !o_cmd[k] && !i_state[k];
    assign age_k      = stamp_now - stamp_r[k];
    assign target     = match_hit ? match_idx : (free_hit ? free_idx : old_idx);
    assign is_steal   = req_start && !match_hit && !free_hit;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
        assign o_midi[7*g +: 7] = midi_r[g];
        assign o_vel[8*g +: 8]  = vel_r[g];
    end

    always_ff @(posedge clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!i_data[15] && (i_data[14:8] == 7'h7f)) state_nxt = S_STOPALL;
                    else                                      state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (last_k) begin
                    if (req_start || match_hit || scan_match) state_nxt = S_APPLY;
                    else                                      state_nxt = S_DROP;
                end
            end
            S_APPLY:   state_nxt = is_steal ? S_KILL : S_DONE;
            S_KILL:    state_nxt = S_DONE;
            S_STOPALL: state_nxt = S_DONE;
            S_DROP:    state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // A killed voice is still counted as allocated during its one-cycle gap.
    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < NUM_VOICES; i++) active_cnt = active_cnt + 4'(o_cmd[i]);
        if (state == S_KILL) active_cnt = active_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_cmd      <= '0;
            o_done     <= 1'b0;
            o_drop     <= 1'b0;
            o_steal    <= 1'b0;
            o_active   <= '0;
            stamp_now  <= '0;
            req_start  <= 1'b0;
            req_note   <= '0;
            req_vel    <= '0;
            k          <= '0;
            match_hit  <= 1'b0;
            free_hit   <= 1'b0;
            match_idx  <= '0;
            free_idx   <= '0;
            old_idx    <= '0;
            old_age    <= '0;
            drop_flag  <= 1'b0;
            steal_flag <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                midi_r[i]  <= 7'h7f;
                vel_r[i]   <= '0;
                stamp_r[i] <= '0;
            end
        end else begin
            o_done   <= 1'b0;
            o_drop   <= 1'b0;
            o_steal  <= 1'b0;
            o_active <= active_cnt;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_start  <= i_data[15];
                        req_note   <= i_data[14:8];
                        req_vel    <= i_data[7:0];
                        k          <= '0;
                        match_hit  <= 1'b0;
                        free_hit   <= 1'b0;
                        drop_flag  <= 1'b0;
                        steal_flag <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (scan_match && !match_hit) begin
                        match_hit <= 1'b1;
                        match_idx <= k;
                    end
                    if (scan_free && !free_hit) begin
                        free_hit <= 1'b1;
                        free_idx <= k;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if ((k == '0) || (age_k > old_age)) begin
                        old_idx <= k;
                        old_age <= age_k;
                    end
                    if (!last_k) k <= k + IDX_W'(1);
                end
                S_APPLY: begin
                    if (req_start) begin
                        if (is_steal) begin
                            o_cmd[target] <= 1'b0;
                        end else begin
                            o_cmd[target]   <= 1'b1;
                            midi_r[target]  <= req_note;
                            vel_r[target]   <= req_vel;
                            stamp_r[target] <= stamp_now;
                            stamp_now       <= stamp_now + STAMP_W'(1);
                        end
                    end else begin
                        o_cmd[target]  <= 1'b0;
                        midi_r[target] <= 7'h7f;
                    end
                end
                S_KILL: begin
                    o_cmd[target]   <= 1'b1;
                    midi_r[target]  <= req_note;
                    vel_r[target]   <= req_vel;
                    stamp_r[target] <= stamp_now;
                    stamp_now       <= stamp_now + STAMP_W'(1);
                    steal_flag      <= 1'b1;
                end
                S_STOPALL: begin
                    o_cmd <= '0;
                    for (int i = 0; i < NUM_VOICES; i++) midi_r[i] <= 7'h7f;
                end
                S_DROP: drop_flag <= 1'b1;
                S_DONE: begin
                    o_done  <= 1'b1;
                    o_drop  <= drop_flag;
                    o_steal <= steal_flag;
                end
                default: ;
            endcase
        end
    end

endmodule
